// File: rtl/i2c_reg_rd_arbiter.sv
// Arbiter that shares the I2C slave register read port among several requesters.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
`timescale 1ns/1ps
module i2c_reg_rd_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         paddr,
    input  logic [DATA_W-1:0]         pdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

`ifdef ARB_FIXED_PRIO_EN
    // Lowest set request bit wins; scanning downward leaves it as the final pick.
    always_comb begin : pick_fixed
        logic [IDX_W-1:0] j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            j = IDX_W'(i);
            if (req[j]) begin
                win_vld = 1'b1;
                win_idx = j;
            end
        end
    end
`else
    logic [IDX_W-1:0] last_idx_q, last_idx_d;

    // First set bit after last_idx wins; the smallest offset is assigned last.
    always_comb begin : pick_rr
        logic [IDX_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = IDX_W'((32'(last_idx_q) + 32'(k)) % NUM_REQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

    always_comb begin : next_state
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rd_en_d     = 1'b0;
        paddr_d     = paddr_q;
        rsp_data_d  = rsp_data_q;
`ifndef ARB_FIXED_PRIO_EN
        last_idx_d  = last_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_ISSUE;
                    idx_d   = win_idx;
                    paddr_d = addr_arr[win_idx];
                    rd_en_d = 1'b1;
                    gnt_d   = NUM_REQ'(1) << win_idx;
`ifndef ARB_FIXED_PRIO_EN
                    last_idx_d = win_idx;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = pdata;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            paddr_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_idx_q  <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            paddr_q     <= paddr_d;
`ifndef ARB_FIXED_PRIO_EN
            last_idx_q  <= last_idx_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign paddr     = paddr_q;

endmodule
